jtdd2_shr_arb: RTL
==================

JTDD2_SHR_ARB -- requirements
Module: jtdd2_shr_arb

Interface
REQ-001 Parameter TOUT_W, default 8, width of the bus-request timeout counter (limit 2^TOUT_W-1 main_cen ticks).
REQ-002 Parameter SETTLE, default 2, consecutive clk cycles sub_busak_n must stay low before the grant is issued (range 1..7).
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rstn  input  1  asynchronous, active-low reset.
REQ-005 main_cen  input  1  main CPU clock enable; qualifies main_req, main_nmi and timeout counting.
REQ-006 main_req  input  1  level from the main CPU halt latch; 1 requests the sub CPU bus, 0 releases it.
REQ-007 main_nmi  input  1  single-cycle strobe from the main CPU; requests a sub CPU NMI.
REQ-008 main_cs  input  1  main CPU access into the shared RAM window.
REQ-009 sub_busak_n  input  1  sub CPU bus acknowledge, active low.
REQ-010 sub_nmi_ack  input  1  sub CPU write to its NMI-acknowledge address.
REQ-011 sub_halt  output  1  bus request to the sub CPU, active high.
REQ-012 sub_nmi_n  output  1  NMI line to the sub CPU, active low.
REQ-013 grant  output  1  main CPU owns shared RAM port B.
REQ-014 main_wait  output  1  stalls the main CPU.
REQ-015 timeout  output  1  sticky flag: bus request was not acknowledged in time.
REQ-016 st  output  2  current state encoding, for debug.

Function
REQ-017 The FSM SHALL have states IDLE=00, REQ=01, GRANT=10, REL=11, updated on every clk.
REQ-018 IDLE: sub_halt=0, grant=0; main_req=1 sampled on main_cen -> REQ, and timeout and both counters cleared.
REQ-019 REQ: sub_halt=1; the settle counter increments each clk with sub_busak_n=0 and clears to 0 when sub_busak_n=1.
REQ-020 REQ: when the settle counter reaches SETTLE -> GRANT; grant rises on the first GRANT cycle, i.e. SETTLE+1 clk after busak_n falls.
REQ-021 REQ: the timeout counter increments on main_cen; on reaching 2^TOUT_W-1 -> IDLE with timeout=1 and sub_halt deasserted on the next clk.
REQ-022 REQ: main_req=0 on main_cen -> IDLE with no grant issued; this takes precedence over settle completion in the same cycle.
REQ-023 GRANT: sub_halt=1, grant=1; main_req=0 on main_cen -> REL.
REQ-024 GRANT: sub_busak_n=1 (spurious release) -> REL immediately and grant drops the same clk the state changes.
REQ-025 REL: sub_halt=0, grant=0; sub_busak_n=1 -> IDLE; main_req=1 while in REL is ignored until IDLE.
REQ-026 main_wait SHALL be combinational: main_cs & ~grant & (state==REQ); accesses in IDLE and REL are not stalled, and port B writes are gated by grant.
REQ-027 NMI: main_nmi & main_cen sets the pending flag; sub_nmi_ack clears it; sub_nmi_n = ~pending.
REQ-028 NMI: set and ack in the same clk leaves pending=1 (set wins); pending is held, not lost, during GRANT.
REQ-029 The timeout counter saturates and never wraps; settle counter width is 3 bits.

Reset
REQ-030 rstn=0 SHALL asynchronously force IDLE, sub_halt=0, grant=0, sub_nmi_n=1, timeout=0, counters=0, st=00.
REQ-031 Reset asserted in GRANT SHALL drop grant and sub_halt in the same cycle without passing through REL.

Structure
REQ-032 State encodings and the SETTLE/TOUT_W defaults SHALL live in package jtdd2_arb_pkg.
REQ-033 The NMI pending flag SHALL be one instance of the existing jtframe_ff (sigedge=main_nmi&main_cen, clr=sub_nmi_ack).
REQ-034 All other logic SHALL be a single flat module with no memories.

Verification
REQ-035 main_req=1; busak_n falls 5 clk later -> grant=1 exactly 5+SETTLE+1=8 clk after the sub_halt rise (SETTLE=2).
REQ-036 main_req=1, busak_n held high, TOUT_W=4, main_cen every clk -> timeout=1 and st=00 after 15 ticks; sub_halt=0.
REQ-037 busak_n low 1 clk, high 1 clk, then low -> settle counter restarts; grant appears SETTLE+1 clk after the final fall.
REQ-038 main_cs=1 in REQ -> main_wait=1; main_cs=1 in GRANT -> main_wait=0.
REQ-039 main_nmi and sub_nmi_ack in the same clk -> sub_nmi_n=0; ack alone next clk -> sub_nmi_n=1.
REQ-040 rstn pulsed low mid-GRANT -> grant=0, sub_halt=0 asynchronously; st=00 after release.

Source files
------------

// File: rtl/jtdd2_arb_pkg.sv
// Shared definitions for the main/sub CPU shared-RAM bus arbiter.
// Holds the arbiter state encoding and the default timing parameters.
package jtdd2_arb_pkg;

  // Encoding is visible on the st debug port, so values are fixed.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_REQ   = 2'b01,
    ST_GRANT = 2'b10,
    ST_REL   = 2'b11
  } arb_state_t;

  localparam int TOUT_W_DEF = 8;  // bus-request timeout counter width
  localparam int SETTLE_DEF = 2;  // clk cycles busak_n must stay low before grant
  localparam int SETTLE_W   = 3;  // settle counter width (SETTLE range 1..7)

endpackage

// File: rtl/jtframe_ff.sv
// Single-bit set/clear flag.
// Ports:
//   clk, rstn : clock and asynchronous active-low reset (clears q)
//   sigedge   : set strobe, sampled on the rising clk edge
//   clr       : clear strobe; when both strobes are high the set wins
//   q         : flag output
module jtframe_ff (
  input  logic clk,
  input  logic rstn,
  input  logic sigedge,
  input  logic clr,
  output logic q
);

  // NOTE: sequential state is assigned with non-blocking (<=) so every flop
  // samples the pre-edge values of its inputs regardless of process order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)        q <= 1'b0;
    else if (sigedge) q <= 1'b1;
    else if (clr)     q <= 1'b0;
  end

endmodule

// File: rtl/jtdd2_shr_arb.sv
// Shared-RAM port B arbiter between the main CPU and the sub CPU.
// The main CPU halts the sub CPU through a bus request, waits for a stable
// bus acknowledge, and then owns port B until it releases the request.
// Ports:
//   clk, rstn    : system clock, asynchronous active-low reset
//   main_cen     : main CPU clock enable (qualifies main_req, main_nmi, timeout)
//   main_req     : main CPU bus request level (1 = request, 0 = release)
//   main_nmi     : main CPU strobe requesting a sub CPU NMI
//   main_cs      : main CPU access into the shared RAM window
//   sub_busak_n  : sub CPU bus acknowledge, active low
//   sub_nmi_ack  : sub CPU NMI acknowledge write
//   sub_halt     : bus request to the sub CPU
//   sub_nmi_n    : NMI to the sub CPU, active low
//   grant        : main CPU owns shared RAM port B
//   main_wait    : stalls a main CPU access while the bus is being acquired
//   timeout      : sticky, the last bus request was never acknowledged
//   st           : current arbiter state, for debug
module jtdd2_shr_arb
  import jtdd2_arb_pkg::*;
#(
  parameter int TOUT_W = TOUT_W_DEF,
  parameter int SETTLE = SETTLE_DEF
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       main_cen,
  input  logic       main_req,
  input  logic       main_nmi,
  input  logic       main_cs,
  input  logic       sub_busak_n,
  input  logic       sub_nmi_ack,
  output logic       sub_halt,
  output logic       sub_nmi_n,
  output logic       grant,
  output logic       main_wait,
  output logic       timeout,
  output logic [1:0] st
);

  localparam logic [TOUT_W-1:0]   TOUT_MAX   = '1;
  localparam logic [TOUT_W-1:0]   TOUT_LAST  = {{(TOUT_W-1){1'b1}}, 1'b0};
  localparam logic [SETTLE_W-1:0] SETTLE_CNT = SETTLE_W'(SETTLE);

  arb_state_t          state, state_nxt;
  logic [SETTLE_W-1:0] settle_cnt, settle_nxt;
  logic [TOUT_W-1:0]   tout_cnt, tout_nxt;
  logic                timeout_nxt;
  logic                nmi_pend;

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt   = state;
    settle_nxt  = settle_cnt;
    tout_nxt    = tout_cnt;
    timeout_nxt = timeout;
    case (state)
      ST_IDLE: begin
        if (main_cen && main_req) begin
          state_nxt   = ST_REQ;
          settle_nxt  = '0;
          tout_nxt    = '0;
          timeout_nxt = 1'b0;
        end
      end
      ST_REQ: begin
        // Any high sample of busak_n restarts the settle window.
        settle_nxt = sub_busak_n ? '0 : settle_cnt + SETTLE_W'(1);
        if (main_cen && tout_cnt != TOUT_MAX) tout_nxt = tout_cnt + TOUT_W'(1);
        // A release request wins over both settle completion and timeout.
        if (main_cen && !main_req) begin
          state_nxt = ST_IDLE;
        end else if (!sub_busak_n && settle_cnt == SETTLE_CNT) begin
          state_nxt = ST_GRANT;
        end else if (main_cen && tout_cnt == TOUT_LAST) begin
          state_nxt   = ST_IDLE;
          timeout_nxt = 1'b1;
        end
      end
      ST_GRANT: begin
        // A spurious busak_n release is treated like a normal release.
        if (sub_busak_n || (main_cen && !main_req)) state_nxt = ST_REL;
      end
      ST_REL: begin
        // New requests are ignored until the sub CPU has taken its bus back.
        if (sub_busak_n) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
      tout_cnt   <= '0;
      timeout    <= 1'b0;
    end else begin
      state      <= state_nxt;
      settle_cnt <= settle_nxt;
      tout_cnt   <= tout_nxt;
      timeout    <= timeout_nxt;
    end
  end

  // Outputs decode straight from the state so an asynchronous reset drops
  // grant and sub_halt immediately, without passing through ST_REL.
  assign sub_halt  = (state == ST_REQ) || (state == ST_GRANT);
  assign grant     = (state == ST_GRANT);
  assign main_wait = main_cs & ~grant & (state == ST_REQ);
  assign st        = state;

  jtframe_ff u_nmi (
    .clk     (clk),
    .rstn    (rstn),
    .sigedge (main_nmi & main_cen),
    .clr     (sub_nmi_ack),
    .q       (nmi_pend)
  );

  assign sub_nmi_n = ~nmi_pend;

endmodule
